// File: rtl/ip_ram.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : ip_ram
// Purpose  : Self-checking RAM loop that writes a pass-dependent pattern to a
//            single-port synchronous RAM, then reads it back and checks it.
// Revision : 1.0
// ----------------------------------------------------------------------------
module ip_ram #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [DATA_W-1:0] ram_rdata,
    output logic              rd_err,
    output logic [7:0]        pass_cnt
);

    localparam int          c_DEPTH   = 2 ** ADDR_W;
    localparam [ADDR_W:0]   c_CNT_MAX = {(ADDR_W + 1){1'b1}};

    logic [ADDR_W:0]   rw_cnt_q,    rw_cnt_d;
    logic [7:0]        pass_cnt_q,  pass_cnt_d;
    logic [DATA_W-1:0] ram_rdata_q, ram_rdata_d;
    logic              rd_err_q,    rd_err_d;
    logic              rd_valid_q,  rd_valid_d;
    logic [DATA_W-1:0] exp_q,       exp_d;

    logic [DATA_W-1:0] w_pattern;
    logic              w_rd_phase;

    logic [DATA_W-1:0] mem [c_DEPTH];

    // Upper counter bit selects the read half of each pass.
    assign w_rd_phase = rw_cnt_q[ADDR_W];
    assign w_pattern  = DATA_W'(rw_cnt_q[ADDR_W-1:0]) + DATA_W'(pass_cnt_q);

    always_comb begin
        ram_en    = sys_rst_n;
        ram_we    = sys_rst_n & ~w_rd_phase;
        ram_addr  = rw_cnt_q[ADDR_W-1:0];
        ram_wdata = ram_we ? w_pattern : '0;
    end

    always_comb begin
        rw_cnt_d    = rw_cnt_q + 1'b1;
        pass_cnt_d  = (rw_cnt_q == c_CNT_MAX) ? pass_cnt_q + 8'd1 : pass_cnt_q;
        ram_rdata_d = (ram_en && !ram_we) ? mem[ram_addr] : ram_rdata_q;
        rd_valid_d  = w_rd_phase;
        exp_d       = w_pattern;
        // exp_q pairs with ram_rdata_q, both one cycle behind the address.
        rd_err_d    = rd_err_q | (rd_valid_q && (ram_rdata_q != exp_q));
    end

    always_ff @(posedge sys_clk) begin
        if (ram_en && ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rw_cnt_q    <= '0;
            pass_cnt_q  <= '0;
            ram_rdata_q <= '0;
            rd_err_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            exp_q       <= '0;
        end else begin
            rw_cnt_q    <= rw_cnt_d;
            pass_cnt_q  <= pass_cnt_d;
            ram_rdata_q <= ram_rdata_d;
            rd_err_q    <= rd_err_d;
            rd_valid_q  <= rd_valid_d;
            exp_q       <= exp_d;
        end
    end

    assign ram_rdata = ram_rdata_q;
    assign rd_err    = rd_err_q;
    assign pass_cnt  = pass_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ip_ram.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_ip_ram
// Purpose  : Directed self-checking bench for the ip_ram write/read loop.
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_ip_ram;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       ram_en;
    logic       ram_we;
    logic [4:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;
    logic       rd_err;
    logic [7:0] pass_cnt;

    int total;
    int bad;
    logic [7:0] exp_rdata;
    logic       exp_err;

    ip_ram #(.ADDR_W(5), .DATA_W(8)) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .rd_err   (rd_err),
        .pass_cnt (pass_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Checks cycles c0..c1-1 of pass p, sampling at each falling edge.
    task automatic run_cycles(input int p, input int c0, input int c1);
        logic [7:0] ep;
        logic       ewe;
        logic [7:0] ewd;
        ep = 8'(p % 256);
        for (int c = c0; c < c1; c++) begin
            ewe = (c < 32);
            ewd = ewe ? 8'((c + p) % 256) : 8'd0;
            total++;
            if (ram_en !== 1'b1 || ram_we !== ewe) begin
                bad++;
                $display("FAIL en_we p=%0d c=%0d got en=%b we=%b want en=1 we=%b", p, c, ram_en, ram_we, ewe);
            end
            total++;
            if (ram_addr !== 5'(c % 32)) begin
                bad++;
                $display("FAIL addr p=%0d c=%0d got %0d want %0d", p, c, ram_addr, c % 32);
            end
            total++;
            if (ram_wdata !== ewd) begin
                bad++;
                $display("FAIL wdata p=%0d c=%0d got %0d want %0d", p, c, ram_wdata, ewd);
            end
            total++;
            if (ram_rdata !== exp_rdata) begin
                bad++;
                $display("FAIL rdata p=%0d c=%0d got %0d want %0d", p, c, ram_rdata, exp_rdata);
            end
            total++;
            if (pass_cnt !== ep) begin
                bad++;
                $display("FAIL pass_cnt p=%0d c=%0d got %0d want %0d", p, c, pass_cnt, ep);
            end
            total++;
            if (rd_err !== exp_err) begin
                bad++;
                $display("FAIL rd_err p=%0d c=%0d got %b want %b", p, c, rd_err, exp_err);
            end
            if (p == 255 && c == 31) begin
                total++;
                if (ram_wdata !== 8'd30) begin
                    bad++;
                    $display("FAIL wrap_wdata got %0d want 30", ram_wdata);
                end
            end
            if (c >= 32) exp_rdata = 8'((c - 32 + p) % 256);
            @(negedge sys_clk);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        total++;
        if (ram_en !== 1'b0 || ram_we !== 1'b0) begin
            bad++;
            $display("FAIL %s_en_we got en=%b we=%b want 0 0", tag, ram_en, ram_we);
        end
        total++;
        if (ram_rdata !== 8'd0 || rd_err !== 1'b0 || pass_cnt !== 8'd0 || ram_addr !== 5'd0) begin
            bad++;
            $display("FAIL %s_regs got rdata=%0d err=%b pass=%0d addr=%0d want 0 0 0 0",
                     tag, ram_rdata, rd_err, pass_cnt, ram_addr);
        end
    endtask

    task automatic check_restart(input string tag);
        total++;
        if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 5'd0 || ram_wdata !== 8'd0 ||
            pass_cnt !== 8'd0 || rd_err !== 1'b0) begin
            bad++;
            $display("FAIL %s got en=%b we=%b addr=%0d wdata=%0d pass=%0d err=%b want 1 1 0 0 0 0",
                     tag, ram_en, ram_we, ram_addr, ram_wdata, pass_cnt, rd_err);
        end
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        check_reset_outputs("reset");
        sys_rst_n = 1'b1;
        #1;
        check_restart("release");
        exp_rdata = 8'd0;
        exp_err   = 1'b0;
    endtask

    task automatic test_passes();
        for (int p = 0; p < 300; p++) begin
            run_cycles(p, 0, 64);
        end
    endtask

    // Pass 300 has pass_cnt 44; address 20 should read 64 but is forced to 0xFF.
    task automatic test_corrupt();
        run_cycles(300, 0, 40);
        dut.mem[20] = 8'hFF;
        run_cycles(300, 40, 53);
        total++;
        if (ram_rdata !== 8'hFF || rd_err !== 1'b0) begin
            bad++;
            $display("FAIL corrupt_read got rdata=%0d err=%b want 255 0", ram_rdata, rd_err);
        end
        exp_rdata = 8'd65;
        @(negedge sys_clk);
        exp_err = 1'b1;
        run_cycles(300, 54, 64);
        run_cycles(301, 0, 64);
    endtask

    task automatic test_async_reset();
        run_cycles(302, 0, 40);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(posedge sys_clk);
        @(negedge sys_clk);
        check_reset_outputs("reset_held");
        sys_rst_n = 1'b1;
        #1;
        check_restart("restart");
        exp_rdata = 8'd0;
        exp_err   = 1'b0;
        run_cycles(0, 0, 64);
        run_cycles(1, 0, 8);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        exp_rdata = 8'd0;
        exp_err   = 1'b0;
        sys_rst_n = 1'b0;
        test_reset();
        test_passes();
        test_corrupt();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ip_ram.md
Name: ip_ram

Overview:
- Self-checking on-chip RAM read/write loop.
- Contains a behavioural single-port synchronous RAM and a controller that runs forever after reset:
  - writes a pass-dependent pattern to every address;
  - reads every address back and compares it against the expected value.
- Standalone top-level exercise block. Only clock and reset are required; all other ports are observation outputs and may be left unconnected.

Parameters:
ADDR_W, 5, RAM address width; depth is 2**ADDR_W (32)
DATA_W, 8, RAM data width

Ports:
sys_clk  input  1  system clock; everything changes on its rising edge
sys_rst_n  input  1  reset; asynchronous and active-low
ram_en  output  1  RAM enable (observation)
ram_we  output  1  RAM write enable (observation)
ram_addr  output  ADDR_W  RAM address (observation)
ram_wdata  output  DATA_W  RAM write data (observation)
ram_rdata  output  DATA_W  RAM read data register (observation)
rd_err  output  1  sticky readback-mismatch flag
pass_cnt  output  8  number of completed write/read passes, wraps at 255

Behaviour:
- Reset values (sys_rst_n low, asynchronous):
  - rw_cnt (internal, ADDR_W+1 bits) = 0, pass_cnt = 0, ram_rdata = 0, rd_err = 0;
  - checker pipeline registers = 0;
  - ram_en = 0, ram_we = 0.
- RAM array contents are not reset.
- rw_cnt increments by 1 on every clock while out of reset and wraps 2*DEPTH-1 → 0 (63 → 0).
- pass_cnt increments by 1 (mod 256) on the clock where rw_cnt wraps from 63 to 0.
- Combinational decode, valid only while out of reset:
  - ram_en = 1;
  - ram_we = 1 when rw_cnt < DEPTH (write phase), else 0 (read phase);
  - ram_addr = rw_cnt[ADDR_W-1:0];
  - ram_wdata = (ram_addr + pass_cnt) mod 2**DATA_W in the write phase, 0 in the read phase.
- RAM, on a rising edge with ram_en = 1:
  - if ram_we = 1: mem[ram_addr] <= ram_wdata; ram_rdata holds its value;
  - if ram_we = 0: ram_rdata <= mem[ram_addr].
  - Read latency is 1 clock.
- Checker:
  - registers rd_valid = (read phase) and exp = (ram_addr + pass_cnt) mod 256, each one cycle behind the address;
  - on any clock where rd_valid = 1 and ram_rdata != exp, sets rd_err = 1;
  - rd_err stays 1 until reset.
- Pass boundary: the read of address 31 in pass N is checked on the first cycle of pass N+1. exp is captured before pass_cnt increments, so that check uses the value N.
- Reset mid-operation: all counters and flags clear at once. After release the sequence restarts at a write of address 0 with pass_cnt = 0. Stale RAM contents are overwritten before being read.
- No other handshake; the loop never stops.

Test Plan:
- Reset held 2 cycles → ram_en = 0, ram_we = 0, ram_rdata = 0, rd_err = 0, pass_cnt = 0; after release, first edge writes address 0 with data 0.
- Pass 0 write phase, cycles 0–31 → ram_we = 1, ram_addr = 0..31, ram_wdata = 0..31.
- Pass 0 read phase, cycles 32–63 → ram_we = 0, ram_addr = 0..31; ram_rdata = 0..31, each one cycle after its address; rd_err stays 0.
- Second pass → pass_cnt = 1; writes 1..32; readback 1..32; rd_err stays 0. Run 300 passes including the pass_cnt wrap: at pass_cnt = 255, address 31 data = 30 (8-bit wrap); rd_err stays 0.
- Force one RAM word corrupt via hierarchical deposit during a read phase → rd_err = 1 on the check cycle and remains 1 thereafter, until reset.
- Assert sys_rst_n low mid-read-phase, asynchronously between edges → outputs clear immediately without waiting for a clock edge; after release, ram_addr = 0, ram_we = 1, pass_cnt = 0, rd_err = 0.
